pwm_bank_gen: RTL and testbench
===============================

// Module: pwm_bank_gen
// PURPOSE
//  Parametrised N-channel programmable PWM engine; successor to the fixed per-channel pattern PWMs and the
//  hard-coded 100 kHz divider in the DDS sample top. Programmed via a simple write port driven by the UART
//  register mapper. Per-channel period/high-time/pulse-count/polarity, shadowed updates at period boundary,
//  synchronous multi-channel start, busy/valid status. Outputs feed OBUF/ODDR/OBUFDS stages at top level.
// PARAMETERS
//  NUM_CH   3    number of PWM channels (1..16)
//  PER_W    16   width of period / high-time counters
//  CNT_W    8    width of pulse-count field; 0 = run forever
// PORTS
//  clk_50M     in   1             system clock; single clock domain
//  rst_n       in   1             asynchronous active-low reset
//  cfg_wr      in   1             write strobe, one cycle
//  cfg_ch      in   $clog2(NUM_CH) target channel; values >= NUM_CH ignored
//  cfg_addr    in   2             0=PERIOD 1=HIGH 2=PNUM 3=CTRL
//  cfg_wdata   in   32            LSBs used per field; CTRL: b0 enable, b1 invert, b2 sync_arm
//  sync_start  in   1             one-cycle pulse; launches all ARMED channels on the same edge
//  pwm_out     out  NUM_CH        registered PWM outputs
//  pwm_busy    out  NUM_CH        1 while channel in ARMED or RUN
//  pwm_valid   out  NUM_CH        one-cycle pulse when finite pulse train completes
//  cfg_err     out  1             one-cycle pulse: start attempted with PERIOD < 2
// BEHAVIOUR
//  Reset: all shadow/active regs 0, states IDLE, pwm_out=0, pwm_busy=0, pwm_valid=0, cfg_err=0.
//  Writes: shadow PERIOD/HIGH/PNUM/CTRL updated on the cfg_wr edge. Active PERIOD/HIGH/PNUM loaded from
//   shadow on RUN entry and on every period wrap (cnt==PERIOD-1); a write on the wrap edge applies one
//   period later (active loads pre-write shadow).
//  Per-channel FSM IDLE/ARMED/RUN/DONE:
//   IDLE : CTRL write with enable=1 -> PERIOD<2: stay IDLE, cfg_err pulse; sync_arm=1: ARMED; else RUN.
//   ARMED: sync_start -> RUN; enable cleared -> IDLE.
//   RUN  : cnt 0..PERIOD-1 wraps; pwm_out = (cnt < HIGH) ^ invert. HIGH=0 -> constant inactive,
//          HIGH>=PERIOD -> constant active. On wrap, period counter++; if PNUM!=0 and count reaches PNUM
//          -> DONE, pwm_valid pulses on that edge, pwm_busy falls same edge, pwm_out = invert.
//          enable cleared -> IDLE next edge, pwm_out = invert, no pwm_valid.
//   DONE : holds inactive level; CTRL write with enable=1 restarts (as from IDLE); enable=0 -> IDLE.
//  Latency: CTRL write sampled edge k -> RUN entered and first pwm_out level driven at edge k+1
//   (sync: sync_start sampled edge j -> first level at edge j+1 on all armed channels, skew 0).
//  Outputs always registered; no combinational path from inputs to pwm_out.
//  Invert toggled while RUN takes effect next edge (not deferred to wrap).
//  Reset asserted mid-run: outputs go 0 immediately (async), counters cleared, no valid pulse.
//  Simultaneous sync_start and CTRL write to same ARMED channel: write wins (re-evaluated from IDLE rules).
//  Pulse counter saturates width CNT_W; PNUM=255 runs exactly 255 periods.
// STRUCTURE
//  Package pwm_bank_pkg: field addresses (ADDR_PERIOD..ADDR_CTRL), CTRL bit indices, FSM state encoding.
//  Sub-module pwm_bank_ch (one channel: shadow regs, FSM, counters), instantiated NUM_CH times by
//  generate; top handles address decode, sync_start fan-out, cfg_err OR-reduction.
// TESTING
//  1 ch0 PERIOD=500 HIGH=250 PNUM=0 enable -> 100 kHz 50% square on pwm_out[0], first high 1 cycle after write.
//  2 ch1 PERIOD=10 HIGH=3 PNUM=4 -> exactly 4 pulses of 3 cycles, pwm_valid[1] one cycle, busy falls same edge.
//  3 ch0,ch2 sync_arm+enable, sync_start after 20 cycles -> both rise on same edge; busy high while ARMED.
//  4 HIGH changed 3->7 mid-run (PERIOD=10) -> current period keeps 3, next period 7; HIGH=0/12 -> const 0/1.
//  5 PERIOD=1 enable -> cfg_err pulse, channel stays IDLE, pwm_out=0; cfg_ch=NUM_CH write -> no effect.
//  6 rst_n low mid pulse train, invert=1 -> pwm_out 0 immediately, no pwm_valid; after release all IDLE.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: register field addresses, CTRL bit positions
// and the per-channel state encoding.
package pwm_bank_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_PNUM   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;
  localparam int CTRL_ARM = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } ch_state_e;

endpackage

// File: rtl/pwm_bank_if.sv
// Configuration write port of the PWM bank, driven by the register mapper.
interface pwm_bank_if #(
  parameter int CH_W = 2
);
  logic            cfg_wr;
  logic [CH_W-1:0] cfg_ch;
  logic [1:0]      cfg_addr;
  logic [31:0]     cfg_wdata;

  modport master (output cfg_wr, output cfg_ch, output cfg_addr, output cfg_wdata);
  modport slave  (input  cfg_wr, input  cfg_ch, input  cfg_addr, input  cfg_wdata);
endinterface

// File: rtl/pwm_bank_ch.sv
// One PWM channel: shadow registers, IDLE/ARMED/RUN/DONE control and period/pulse counters.
// CTRL writes and sync_start arrive registered, so the first output level appears one edge later.
module pwm_bank_ch
  import pwm_bank_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        sync_start,
  output logic        pwm_out,
  output logic        pwm_busy,
  output logic        pwm_valid,
  output logic        cfg_err
);

  ch_state_e        state_q, state_d;
  logic [PER_W-1:0] per_sh_q, per_sh_d, high_sh_q, high_sh_d;
  logic [PER_W-1:0] per_a_q, per_a_d, high_a_q, high_a_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] pnum_sh_q, pnum_sh_d, pnum_a_q, pnum_a_d, pcnt_q, pcnt_d, pcnt_inc;
  logic             en_q, en_d, inv_q, inv_d, arm_q, arm_d;
  logic             ctrl_wr_q, ctrl_wr_d;
  logic             out_q, out_d, valid_q, valid_d, err_q, err_d;
  logic             start_run, load_act;

  always_comb begin
    state_d   = state_q;
    per_sh_d  = per_sh_q;
    high_sh_d = high_sh_q;
    pnum_sh_d = pnum_sh_q;
    en_d      = en_q;
    inv_d     = inv_q;
    arm_d     = arm_q;
    per_a_d   = per_a_q;
    high_a_d  = high_a_q;
    pnum_a_d  = pnum_a_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    start_run = 1'b0;
    load_act  = 1'b0;
    ctrl_wr_d = wr_en && (wr_addr == ADDR_CTRL);
    pcnt_inc  = (&pcnt_q) ? pcnt_q : pcnt_q + CNT_W'(1);

    if (wr_en) begin
      case (wr_addr)
        ADDR_PERIOD: per_sh_d  = wr_data[PER_W-1:0];
        ADDR_HIGH:   high_sh_d = wr_data[PER_W-1:0];
        ADDR_PNUM:   pnum_sh_d = wr_data[CNT_W-1:0];
        default: begin
          en_d  = wr_data[CTRL_EN];
          inv_d = wr_data[CTRL_INV];
          arm_d = wr_data[CTRL_ARM];
        end
      endcase
    end

    // Outside RUN a CTRL write is always re-evaluated, so it beats a coincident sync_start.
    if (ctrl_wr_q && (state_q != ST_RUN)) begin
      if (!en_q) begin
        state_d = ST_IDLE;
      end else if (per_sh_q < PER_W'(2)) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else if (arm_q) begin
        state_d = ST_ARMED;
      end else begin
        start_run = 1'b1;
      end
    end else if ((state_q == ST_ARMED) && sync_start) begin
      start_run = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (ctrl_wr_q && !en_q) begin
        state_d = ST_IDLE;
      end else if (cnt_q == per_a_q - PER_W'(1)) begin
        cnt_d    = '0;
        load_act = 1'b1;
        pcnt_d   = pcnt_inc;
        if ((pnum_a_q != '0) && (pcnt_inc == pnum_a_q)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end

    if (start_run) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      pcnt_d   = '0;
      load_act = 1'b1;
    end
    if (load_act) begin
      per_a_d  = per_sh_q;
      high_a_d = high_sh_q;
      pnum_a_d = pnum_sh_q;
    end

    out_d = (state_d == ST_RUN) ? ((cnt_d < high_a_d) ^ inv_q) : inv_q;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      per_sh_q  <= '0;
      high_sh_q <= '0;
      pnum_sh_q <= '0;
      en_q      <= 1'b0;
      inv_q     <= 1'b0;
      arm_q     <= 1'b0;
      per_a_q   <= '0;
      high_a_q  <= '0;
      pnum_a_q  <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      ctrl_wr_q <= 1'b0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_sh_q  <= per_sh_d;
      high_sh_q <= high_sh_d;
      pnum_sh_q <= pnum_sh_d;
      en_q      <= en_d;
      inv_q     <= inv_d;
      arm_q     <= arm_d;
      per_a_q   <= per_a_d;
      high_a_q  <= high_a_d;
      pnum_a_q  <= pnum_a_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      ctrl_wr_q <= ctrl_wr_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^wr_data;

  assign pwm_out   = out_q;
  assign pwm_busy  = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign pwm_valid = valid_q;
  assign cfg_err   = err_q;

endmodule

// File: rtl/pwm_bank_gen.sv
// N-channel programmable PWM bank: channel write decode, registered sync_start
// fan-out to every channel and OR-combined configuration error.
module pwm_bank_gen
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int PER_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  pwm_bank_if.slave         cfg,
  input  logic              sync_start,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_busy,
  output logic [NUM_CH-1:0] pwm_valid,
  output logic              cfg_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   ch_sel;
  logic [NUM_CH-1:0] err_vec;
  logic              sync_q, sync_d;

  assign ch_sel = cfg.cfg_ch;

  always_comb begin
    sync_d = sync_start;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Channel indices at or above NUM_CH match no instance, so such writes are dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_hit;
    assign wr_hit = cfg.cfg_wr && (ch_sel == CH_W'(gi));

    pwm_bank_ch #(
      .PER_W (PER_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .wr_en      (wr_hit),
      .wr_addr    (cfg.cfg_addr),
      .wr_data    (cfg.cfg_wdata),
      .sync_start (sync_q),
      .pwm_out    (pwm_out[gi]),
      .pwm_busy   (pwm_busy[gi]),
      .pwm_valid  (pwm_valid[gi]),
      .cfg_err    (err_vec[gi])
    );
  end

  assign cfg_err = |err_vec;

endmodule

// File: tb/tb_pwm_bank_gen.sv
// Directed checks of pwm_bank_gen: free-running square, finite trains, sync start,
// shadowed HIGH updates, period error, ignored channel index and mid-run reset.
module tb_pwm_bank_gen;
  import pwm_bank_pkg::*;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sync_start = 1'b0;
  logic [2:0] pwm_out, pwm_busy, pwm_valid;
  logic       cfg_err;
  int         total = 0;
  int         bad   = 0;

  pwm_bank_if #(.CH_W(2)) cfg_bus ();

  pwm_bank_gen #(.NUM_CH(3), .PER_W(16), .CNT_W(8)) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .cfg        (cfg_bus.slave),
    .sync_start (sync_start),
    .pwm_out    (pwm_out),
    .pwm_busy   (pwm_busy),
    .pwm_valid  (pwm_valid),
    .cfg_err    (cfg_err)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] addr, input logic [31:0] data);
    cfg_bus.cfg_wr    = 1'b1;
    cfg_bus.cfg_ch    = ch;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_wdata = data;
    step(1);
    cfg_bus.cfg_wr    = 1'b0;
  endtask

  initial begin
    int hi, hi_b, rises, first_fall, vcnt, vidx, vbusy, busy40;
    logic prev, cur, any_v, any_b, any_o;

    cfg_bus.cfg_wr = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_wdata = '0;
    step(3);
    check("rst_out", 32'(pwm_out), 0);
    check("rst_busy_valid_err", 32'({pwm_busy, pwm_valid, cfg_err}), 0);
    rst_n = 1'b1;
    step(2);

    // 1: ch0 500/250 free-running
    wr(0, ADDR_PERIOD, 500); wr(0, ADDR_HIGH, 250); wr(0, ADDR_PNUM, 0); wr(0, ADDR_CTRL, 1);
    check("t1_pre_out", 32'(pwm_out[0]), 0);
    step(1);
    check("t1_first_high", 32'(pwm_out[0]), 1);
    check("t1_busy", 32'(pwm_busy[0]), 1);
    hi = 0; rises = 0; first_fall = -1; prev = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cur = pwm_out[0];
      hi += int'(cur);
      if (prev && !cur && first_fall < 0) first_fall = i;
      if (!prev && cur) rises++;
      prev = cur;
      step(1);
    end
    check("t1_high_cycles", 32'(hi), 500);
    check("t1_first_fall", 32'(first_fall), 250);
    check("t1_rises", 32'(rises), 1);
    wr(0, ADDR_CTRL, 0);
    step(1);
    check("t1_stop", 32'({pwm_out[0], pwm_busy[0]}), 0);

    // 2: ch1 10/3 x4
    wr(1, ADDR_PERIOD, 10); wr(1, ADDR_HIGH, 3); wr(1, ADDR_PNUM, 4); wr(1, ADDR_CTRL, 1);
    hi = 0; rises = 0; vcnt = 0; vidx = -1; vbusy = -1; busy40 = -1; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cur = pwm_out[1];
      hi += int'(cur);
      if (!prev && cur) rises++;
      prev = cur;
      if (pwm_valid[1]) begin vcnt++; vidx = i; vbusy = int'(pwm_busy[1]); end
      if (i == 40) busy40 = int'(pwm_busy[1]);
      step(1);
    end
    check("t2_high_cycles", 32'(hi), 12);
    check("t2_pulses", 32'(rises), 4);
    check("t2_valid_count", 32'(vcnt), 1);
    check("t2_valid_cycle", 32'(vidx), 41);
    check("t2_busy_at_valid", 32'(vbusy), 0);
    check("t2_busy_last_period", 32'(busy40), 1);
    check("t2_done_out", 32'(pwm_out[1]), 0);

    // 3: ch0+ch2 armed then sync launch
    wr(0, ADDR_PERIOD, 10); wr(0, ADDR_HIGH, 5);
    wr(2, ADDR_PERIOD, 10); wr(2, ADDR_HIGH, 5);
    wr(0, ADDR_CTRL, 5); wr(2, ADDR_CTRL, 5);
    step(20);
    check("t3_armed_busy", 32'({pwm_busy[2], pwm_busy[0]}), 3);
    check("t3_armed_out", 32'({pwm_out[2], pwm_out[0]}), 0);
    sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
    check("t3_pre_launch", 32'({pwm_out[2], pwm_out[0]}), 0);
    step(1);
    check("t3_launch_same_edge", 32'({pwm_out[2], pwm_out[0]}), 3);

    // 4: HIGH 3->7 mid-period, then HIGH=0 / 12, then invert
    wr(0, ADDR_CTRL, 0); wr(2, ADDR_CTRL, 0);
    step(2);
    wr(0, ADDR_HIGH, 3); wr(0, ADDR_CTRL, 1);
    step(2);
    wr(0, ADDR_HIGH, 7);
    hi = 0; hi_b = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 8) hi += int'(pwm_out[0]); else hi_b += int'(pwm_out[0]);
      step(1);
    end
    check("t4_cur_period_high", 32'(hi), 1);
    check("t4_next_period_high", 32'(hi_b), 7);
    wr(0, ADDR_HIGH, 0);
    step(20);
    hi = 0;
    for (int i = 0; i < 10; i++) begin hi += int'(pwm_out[0]); step(1); end
    check("t4_high0_const", 32'(hi), 0);
    wr(0, ADDR_HIGH, 12);
    step(20);
    hi = 0;
    for (int i = 0; i < 10; i++) begin hi += int'(pwm_out[0]); step(1); end
    check("t4_high12_const", 32'(hi), 10);
    wr(0, ADDR_CTRL, 3);
    check("t4_inv_write_edge", 32'(pwm_out[0]), 1);
    step(1);
    check("t4_inv_next_edge", 32'(pwm_out[0]), 0);
    wr(0, ADDR_CTRL, 0);
    step(1);
    check("t4_stop", 32'({pwm_out[0], pwm_busy[0]}), 0);

    // 5: PERIOD<2 error, out-of-range channel
    wr(2, ADDR_PERIOD, 1); wr(2, ADDR_CTRL, 1);
    check("t5_err_pre", 32'(cfg_err), 0);
    step(1);
    check("t5_err_pulse", 32'(cfg_err), 1);
    check("t5_err_busy", 32'(pwm_busy[2]), 0);
    step(1);
    check("t5_err_one_cycle", 32'(cfg_err), 0);
    check("t5_err_out", 32'(pwm_out[2]), 0);
    wr(3, ADDR_CTRL, 1);
    step(3);
    check("t5_badch_busy", 32'(pwm_busy), 0);
    check("t5_badch_out_err", 32'({pwm_out, cfg_err}), 0);

    // 6: restart ch1 from DONE with invert, reset mid-train
    wr(1, ADDR_CTRL, 3);
    step(1);
    check("t6_inv_run_low", 32'({pwm_busy[1], pwm_out[1]}), 2);
    step(5);
    check("t6_inv_idle_high", 32'(pwm_out[1]), 1);
    rst_n = 1'b0;
    #2;
    check("t6_async_out", 32'(pwm_out), 0);
    check("t6_async_busy_valid", 32'({pwm_busy, pwm_valid}), 0);
    step(3);
    rst_n = 1'b1;
    step(2);
    any_v = 1'b0; any_b = 1'b0; any_o = 1'b0;
    for (int i = 0; i < 50; i++) begin
      any_v |= |pwm_valid; any_b |= |pwm_busy; any_o |= |pwm_out;
      step(1);
    end
    check("t6_post_valid", 32'(any_v), 0);
    check("t6_post_busy", 32'(any_b), 0);
    check("t6_post_out", 32'(any_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
